// File: rtl/intra_delay_sampler.sv
// Captures b|c on request and replays it exactly DELAY cycles later.
// Pending captures sit in an in-order queue tagged with their due timestamp.
module intra_delay_sampler #(
    parameter int DELAY = 25,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       b,
    input  logic                       c,
    input  logic                       cap,
    output logic                       cap_ready,
    output logic                       d,
    output logic                       d_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       drop_err
);
    localparam int NW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic          value;
        logic [CW-1:0] due;
    } entry_t;

    logic [CW-1:0] tcnt;
    entry_t        q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    // cap_ready follows registered count only, so a same-cycle pop never frees a slot early.
    assign cap_ready = (count != NW'(DEPTH));
    assign push      = cap & cap_ready;
    // Fixed delay keeps due stamps monotonic, so only the head ever needs comparing.
    assign pop       = (count != '0) && (tcnt == q[rd_ptr].due);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            wr_ptr <= '0;
        end else if (push) begin
            q[wr_ptr] <= '{value: b | c, due: tcnt + CW'(DELAY)};
            wr_ptr    <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            d       <= 1'b0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= pop;
            if (pop) begin
                d      <= q[rd_ptr].value;
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (cap && !cap_ready) begin
            drop_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_intra_delay_sampler.sv
// Directed bench: default, wrapped-timestamp (CW=5) and DELAY=1 instances share clock, reset and operands.
module tb_intra_delay_sampler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic b = 1'b0, c = 1'b0;
    logic cap0 = 1'b0, cap1 = 1'b0, cap2 = 1'b0;
    logic rdy0, rdy1, rdy2, d0, d1, d2, dv0, dv1, dv2, drop0, drop1, drop2;
    logic [2:0] cnt0, cnt1, cnt2;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int rel_cyc[$];
    logic rel_d[$];

    always #5 clk = ~clk;

    intra_delay_sampler u0 (
        .clk(clk), .rst_n(rst_n), .b(b), .c(c), .cap(cap0), .cap_ready(rdy0),
        .d(d0), .d_valid(dv0), .count(cnt0), .drop_err(drop0));

    intra_delay_sampler #(.DELAY(25), .DEPTH(4), .CW(5)) u1 (
        .clk(clk), .rst_n(rst_n), .b(b), .c(c), .cap(cap1), .cap_ready(rdy1),
        .d(d1), .d_valid(dv1), .count(cnt1), .drop_err(drop1));

    intra_delay_sampler #(.DELAY(1), .DEPTH(4), .CW(8)) u2 (
        .clk(clk), .rst_n(rst_n), .b(b), .c(c), .cap(cap2), .cap_ready(rdy2),
        .d(d2), .d_valid(dv2), .count(cnt2), .drop_err(drop2));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle; logs every u0 release with its edge number.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (dv0) begin
            rel_cyc.push_back(cyc);
            rel_d.push_back(d0);
        end
    endtask

    task automatic clear_log();
        rel_cyc.delete();
        rel_d.delete();
    endtask

    initial begin
        int cap_cyc, first, n_rel, rel_at, rel_val;
        logic [3:0] pat;
        logic last;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d", d0, 0);
        chk("rst_dv", dv0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_drop", drop0, 0);
        chk("rst_ready", rdy0, 1);

        // single capture, operand changes after capture must not leak
        @(negedge clk);
        rst_n = 1'b1;
        b = 1'b1; c = 1'b0; cap0 = 1'b1;
        clear_log();
        step();
        cap0 = 1'b0;
        cap_cyc = cyc;
        chk("A_count", cnt0, 1);
        for (int i = 1; i <= 30; i++) begin
            if (i == 10) b = 1'b0;
            step();
            if (i == 24) chk("A_d_before", d0, 0);
        end
        chk("A_nrel", rel_cyc.size(), 1);
        chk("A_rel_cyc", rel_cyc.size() > 0 ? rel_cyc[0] : -1, cap_cyc + 25);
        chk("A_rel_d", rel_d.size() > 0 ? int'(rel_d[0]) : -1, 1);
        chk("A_d_hold", d0, 1);
        chk("A_dv_idle", dv0, 0);

        // four back-to-back captures 1,0,1,1
        pat = 4'b1101;
        c = 1'b0;
        clear_log();
        for (int j = 0; j < 4; j++) begin
            b = pat[j];
            cap0 = 1'b1;
            step();
            if (j == 0) first = cyc;
        end
        cap0 = 1'b0;
        chk("B_count_peak", cnt0, 4);
        chk("B_ready_full", rdy0, 0);
        repeat (30) step();
        chk("B_nrel", rel_cyc.size(), 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("B_rel_cyc%0d", j), j < rel_cyc.size() ? rel_cyc[j] : -1, first + 25 + j);
            chk($sformatf("B_rel_d%0d", j), j < rel_d.size() ? int'(rel_d[j]) : -1, int'(pat[j]));
        end
        chk("B_drop", drop0, 0);
        chk("B_count_end", cnt0, 0);

        // overflow: fifth capture refused
        b = 1'b1;
        clear_log();
        for (int j = 0; j < 5; j++) begin
            if (j == 4) chk("C_ready_full", rdy0, 0);
            cap0 = 1'b1;
            step();
            if (j == 0) first = cyc;
        end
        cap0 = 1'b0;
        chk("C_drop", drop0, 1);
        chk("C_count", cnt0, 4);
        repeat (35) step();
        chk("C_nrel", rel_cyc.size(), 4);
        chk("C_rel_first", rel_cyc.size() > 0 ? rel_cyc[0] : -1, first + 25);
        chk("C_rel_last", rel_cyc.size() > 3 ? rel_cyc[3] : -1, first + 28);
        chk("C_drop_sticky", drop0, 1);
        chk("C_count_end", cnt0, 0);

        // reset mid-wait discards pending captures
        b = 1'b0; c = 1'b1; cap0 = 1'b1;
        repeat (2) step();
        cap0 = 1'b0;
        chk("D_count", cnt0, 2);
        repeat (10) step();
        chk("D_d_pre", d0, 1);
        rst_n = 1'b0;
        #2;
        chk("D_rst_d", d0, 0);
        chk("D_rst_dv", dv0, 0);
        chk("D_rst_count", cnt0, 0);
        chk("D_rst_drop", drop0, 0);
        chk("D_rst_ready", rdy0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        repeat (40) step();
        chk("D_no_rel", rel_cyc.size(), 0);

        // CW=5: capture at tcnt=20, release at tcnt=13 after wrap
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();
        b = 1'b0; c = 1'b1; cap1 = 1'b1;
        step();
        cap1 = 1'b0;
        c = 1'b0;
        cap_cyc = cyc;
        n_rel = 0; rel_at = -1; rel_val = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dv1) begin
                n_rel++;
                rel_at = cyc;
                rel_val = int'(d1);
            end
        end
        chk("E_nrel", n_rel, 1);
        chk("E_rel_cyc", rel_at, cap_cyc + 25);
        chk("E_rel_d", rel_val, 1);

        // DELAY=1, cap held from first edge after reset
        @(negedge clk);
        rst_n = 1'b0;
        b = 1'($urandom_range(1)); c = 1'($urandom_range(1));
        cap2 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        last = b | c;
        step();
        chk("F_first_count", cnt2, 1);
        chk("F_first_dv", dv2, 0);
        for (int k = 2; k <= 20; k++) begin
            b = 1'($urandom_range(1)); c = 1'($urandom_range(1));
            step();
            chk($sformatf("F_dv%0d", k), dv2, 1);
            chk($sformatf("F_d%0d", k), d2, int'(last));
            chk($sformatf("F_count%0d", k), cnt2, 1);
            last = b | c;
        end
        chk("F_drop", drop2, 0);
        cap2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/intra_delay_sampler.md
INTRA_DELAY_SAMPLER -- requirements
Module: intra_delay_sampler

Interface
REQ-001 SHALL have parameter DELAY, default 25, capture-to-release latency in clk cycles; legal range 1 <= DELAY < 2^CW.
REQ-002 SHALL have parameter DEPTH, default 4, maximum number of outstanding captures; power of two, >= 2.
REQ-003 SHALL have parameter CW, default 8, timestamp counter width.
REQ-004 SHALL have one clock and an asynchronous active-low reset, listed first: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have port b, input, 1 bit: first sampled operand.
REQ-006 SHALL have port c, input, 1 bit: second sampled operand.
REQ-007 SHALL have port cap, input, 1 bit: capture request, sampled each rising edge.
REQ-008 SHALL have port cap_ready, output, 1 bit: capture accepted when high.
REQ-009 SHALL have port d, output, 1 bit: last released value (registered).
REQ-010 SHALL have port d_valid, output, 1 bit: one-cycle pulse marking a release.
REQ-011 SHALL have port count, output, clog2(DEPTH+1) bits: outstanding capture count.
REQ-012 SHALL have port drop_err, output, 1 bit: sticky flag, set when a capture is refused.

Function
REQ-013 SHALL keep a free-running CW-bit timestamp tcnt that increments every cycle out of reset and wraps modulo 2^CW.
REQ-014 Accept condition: on a rising edge with cap=1 and cap_ready=1, SHALL push {value=b|c sampled at that edge, due=(tcnt+DELAY) mod 2^CW} into an in-order queue.
REQ-015 The value SHALL be the one sampled at capture; later changes on b or c SHALL NOT affect it (intra-assignment semantics).
REQ-016 Release condition: when the queue is non-empty and tcnt==head.due at a rising edge, SHALL load d<=head.value, assert d_valid for exactly that following cycle, and pop the head.
REQ-017 Latency SHALL be exactly DELAY cycles: capture at edge k, d and d_valid update at edge k+DELAY.
REQ-018 At most one release per cycle; releases SHALL occur in capture order.
REQ-019 d SHALL hold its last released value between releases; d_valid SHALL be 0 when no release occurs.
REQ-020 cap_ready SHALL equal (count != DEPTH), combinationally from registered count; a same-cycle pop does not raise cap_ready.
REQ-021 Push and pop in the same cycle (not full) SHALL both take effect, leaving count unchanged.
REQ-022 A cap=1 with cap_ready=0 SHALL be ignored (no push), SHALL set drop_err, and drop_err SHALL stay 1 until reset.
REQ-023 Timestamp wrap SHALL not disturb release timing: the due comparison is equality modulo 2^CW.
REQ-024 count SHALL never exceed DEPTH nor underflow; pop with empty queue SHALL NOT occur.

Reset
REQ-025 On rst_n=0, asynchronously: d=0, d_valid=0, count=0, drop_err=0, tcnt=0, queue emptied; cap_ready=1 once count=0.
REQ-026 Reset asserted mid-operation SHALL discard all pending captures; no release SHALL occur for them after rst_n returns high.
REQ-027 The first capture SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-028 Defaults; b=1,c=0, cap pulse at cycle 0, b=0 at cycle 10 -> d=1 with d_valid pulse at cycle 25; d=0 before.
REQ-029 Defaults; cap on 4 consecutive cycles with b|c=1,0,1,1 -> releases at +25..+28 with d=1,0,1,1, count peaks at 4.
REQ-030 Defaults; 5 consecutive caps -> 5th refused (cap_ready=0), drop_err=1, exactly 4 releases.
REQ-031 CW=5, DELAY=25; capture when tcnt=20 -> release when tcnt=13, exactly 25 cycles later.
REQ-032 Defaults; 2 captures pending, pulse rst_n low mid-wait -> d=0, d_valid=0, count=0 immediately; no d_valid for 40 cycles afterwards.
REQ-033 DELAY=1; cap held high, random b,c -> d_valid high every cycle after the first, d equals previous-cycle b|c, count stays 1, drop_err stays 0.
